bus_grant_scheduler: RTL and testbench

BUS_GRANT_SCHEDULER -- requirements
Module: bus_grant_scheduler

---
 rtl/bus_grant_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_bus_grant_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_grant_scheduler.sv
// bus_grant_scheduler
// Three-master / three-slave bus arbiter. Masters are granted round-robin,
// the winner shifts a two-bit slave address in serially (MSB first), the
// scheduler waits for the addressed slave, routes the datapath until the
// master lets go, then idles the bus for IDLE_GAP cycles before re-arbitrating.
// A watchdog forces the bus free if a transfer stalls in WAIT_SLAVE or ROUTE
// for TIMEOUT non-hold cycles. Slave index 3 means "no slave": the transfer
// is dropped straight into RELEASE without routing.
// IDLE_GAP values below 1 behave as 1, and values above 256 are not supported
// by the 8-bit gap counter.

module bus_grant_scheduler #(
  parameter logic [7:0] TIMEOUT  = 8'd200,
  parameter int         IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] m_req,
  input  logic [2:0] m_addr,
  input  logic [2:0] m_addr_valid,
  input  logic [2:0] s_ready,
  input  logic [2:0] s_hold,
  output logic [2:0] grant,
  output logic [1:0] slave_sel,
  output logic       route_en,
  output logic       timeout_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_GRANT      = 3'd1,
    S_DECODE     = 3'd2,
    S_WAIT_SLAVE = 3'd3,
    S_ROUTE      = 3'd4,
    S_RELEASE    = 3'd5
  } state_t;

  // RELEASE lasts IDLE_GAP cycles: the gap counter starts at 0 on entry and
  // the last RELEASE cycle is the one where it equals IDLE_GAP-1.
  localparam int         GAP_LAST_INT = (IDLE_GAP > 1) ? IDLE_GAP - 1 : 0;
  localparam logic [7:0] GAP_LAST     = 8'(GAP_LAST_INT);

  // The watchdog fires on the cycle whose increment would make the counter
  // reach TIMEOUT, so the counter reads TIMEOUT in the first RELEASE cycle.
  localparam logic [7:0] TIMEOUT_LAST = TIMEOUT - 8'd1;

  localparam logic [1:0] NO_SLAVE = 2'd3;

  state_t     cur_state;
  state_t     next_state;

  // Arbitration state.
  logic       armed;
  logic [1:0] winner;
  logic [1:0] last_winner;
  logic [1:0] rr_pick;

  // Address capture and slave selection.
  logic       sel_hi;
  logic [1:0] slave_sel_q;
  logic       decode_done;

  // Watchdog and release gap.
  logic [7:0] to_cnt;
  logic [7:0] gap_cnt;
  logic       timeout_hit;
  logic       timeout_err_q;

  // One-hot views and per-winner / per-slave selected inputs.
  logic [2:0] win_oh;
  logic [2:0] sel_oh;
  logic       win_req;
  logic       win_valid;
  logic       win_addr;
  logic       slave_rdy;
  logic       slave_hold;
  logic       in_xfer;

  // Decode the registered winner and selected slave into one-hot masks.
  always_comb begin
    win_oh = 3'b000;
    case (winner)
      2'd0:    win_oh = 3'b001;
      2'd1:    win_oh = 3'b010;
      2'd2:    win_oh = 3'b100;
      default: win_oh = 3'b000;
    endcase
    sel_oh = 3'b000;
    case (slave_sel_q)
      2'd0:    sel_oh = 3'b001;
      2'd1:    sel_oh = 3'b010;
      2'd2:    sel_oh = 3'b100;
      default: sel_oh = 3'b000;
    endcase
  end

  // Only the winning master's and the addressed slave's signals matter;
  // everything else on the request side is ignored until the next IDLE.
  assign win_req     = |(m_req        & win_oh);
  assign win_valid   = |(m_addr_valid & win_oh);
  assign win_addr    = |(m_addr       & win_oh);
  assign slave_rdy   = |(s_ready      & sel_oh);
  assign slave_hold  = |(s_hold       & sel_oh);
  assign in_xfer     = (cur_state == S_WAIT_SLAVE) || (cur_state == S_ROUTE);
  assign decode_done = (cur_state == S_DECODE) && win_req && win_valid;

  // Round-robin pick: search starts at the master after the last winner.
  always_comb begin
    rr_pick = 2'd0;
    case (last_winner)
      2'd0: begin
        if (m_req[1])      rr_pick = 2'd1;
        else if (m_req[2]) rr_pick = 2'd2;
        else               rr_pick = 2'd0;
      end
      2'd1: begin
        if (m_req[2])      rr_pick = 2'd2;
        else if (m_req[0]) rr_pick = 2'd0;
        else               rr_pick = 2'd1;
      end
      default: begin
        if (m_req[0])      rr_pick = 2'd0;
        else if (m_req[1]) rr_pick = 2'd1;
        else               rr_pick = 2'd2;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Next-state logic; a dropped request always wins over other exits, and
  // the watchdog wins over a slave that becomes ready on the same cycle.
  always_comb begin
    next_state  = cur_state;
    timeout_hit = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (armed && (|m_req)) next_state = S_GRANT;
      end
      S_GRANT: begin
        if (!win_req)       next_state = S_RELEASE;
        else if (win_valid) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (!win_req) begin
          next_state = S_RELEASE;
        end else if (win_valid) begin
          if ({sel_hi, win_addr} == NO_SLAVE) next_state = S_RELEASE;
          else                                next_state = S_WAIT_SLAVE;
        end
      end
      S_WAIT_SLAVE: begin
        if (!win_req) begin
          next_state = S_RELEASE;
        end else if (!slave_hold && (to_cnt == TIMEOUT_LAST)) begin
          next_state  = S_RELEASE;
          timeout_hit = 1'b1;
        end else if (slave_rdy) begin
          next_state = S_ROUTE;
        end
      end
      S_ROUTE: begin
        if (!win_req) begin
          next_state = S_RELEASE;
        end else if (!slave_hold && (to_cnt == TIMEOUT_LAST)) begin
          next_state  = S_RELEASE;
          timeout_hit = 1'b1;
        end
      end
      S_RELEASE: begin
        if (gap_cnt == GAP_LAST) next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Arbitration, address capture, watchdog and gap bookkeeping. The armed
  // flag keeps IDLE from granting on the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed         <= 1'b0;
      winner        <= 2'd0;
      last_winner   <= 2'd2;
      sel_hi        <= 1'b0;
      slave_sel_q   <= NO_SLAVE;
      to_cnt        <= 8'd0;
      gap_cnt       <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      armed         <= 1'b1;
      timeout_err_q <= timeout_hit;

      if ((cur_state == S_IDLE) && (next_state == S_GRANT)) begin
        winner <= rr_pick;
      end

      if ((cur_state == S_GRANT) && (next_state == S_DECODE)) begin
        sel_hi <= win_addr;
      end

      if (decode_done) begin
        slave_sel_q <= {sel_hi, win_addr};
      end else if (next_state == S_IDLE) begin
        slave_sel_q <= NO_SLAVE;
      end

      if ((cur_state == S_DECODE) && (next_state == S_WAIT_SLAVE)) begin
        to_cnt <= 8'd0;
      end else if (in_xfer && !slave_hold) begin
        to_cnt <= to_cnt + 8'd1;
      end

      if (cur_state == S_RELEASE) begin
        gap_cnt <= gap_cnt + 8'd1;
      end else begin
        gap_cnt <= 8'd0;
      end

      if ((cur_state == S_RELEASE) && (next_state == S_IDLE)) begin
        last_winner <= winner;
      end
    end
  end

  // Outputs are derived from registered state only, so reset clears them at once.
  always_comb begin
    grant = 3'b000;
    if ((cur_state == S_GRANT) || (cur_state == S_DECODE) ||
        (cur_state == S_WAIT_SLAVE) || (cur_state == S_ROUTE)) begin
      grant = win_oh;
    end
  end

  assign route_en    = (cur_state == S_ROUTE);
  assign slave_sel   = slave_sel_q;
  assign timeout_err = timeout_err_q;
  assign state       = cur_state;

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// tb_bus_grant_scheduler
// Directed table of transactions, randomized transactions predicted by a
// round-robin model, and hand-written sequences for reset, timeout and hold.

module tb_bus_grant_scheduler;

  localparam int         IDLE_GAP = 2;
  localparam logic [7:0] TIMEOUT  = 8'd200;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_ROUTE   = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  logic       clk;
  logic       reset;
  logic [2:0] m_req;
  logic [2:0] m_addr;
  logic [2:0] m_addr_valid;
  logic [2:0] s_ready;
  logic [2:0] s_hold;
  logic [2:0] grant;
  logic [1:0] slave_sel;
  logic       route_en;
  logic       timeout_err;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int model_last;

  typedef struct {
    logic [2:0] req;
    logic [1:0] addr;
    int         rdy_delay;
    logic [2:0] exp_grant;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[6];

  bus_grant_scheduler #(
    .TIMEOUT (TIMEOUT),
    .IDLE_GAP(IDLE_GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m_req       (m_req),
    .m_addr      (m_addr),
    .m_addr_valid(m_addr_valid),
    .s_ready     (s_ready),
    .s_hold      (s_hold),
    .grant       (grant),
    .slave_sel   (slave_sel),
    .route_en    (route_en),
    .timeout_err (timeout_err),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_for_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    check_output("wait_for_state", 32'(state), 32'(s));
  endtask

  // Round-robin reference: first requester at or after (last+1) mod 3.
  function automatic int rr_winner(input logic [2:0] req, input int last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int onehot_index(input logic [2:0] oh);
    for (int i = 0; i < 3; i++) begin
      if (oh[i]) return i;
    end
    return -1;
  endfunction

  // Shift one address bit in for the winner, after some invalid wait cycles.
  task automatic send_bit(input int gaps, input logic b, input logic [2:0] g, input logic [2:0] stay);
    logic [2:0] noise;
    for (int i = 0; i < gaps; i++) begin
      noise        = 3'($urandom);
      m_req        = g | noise;
      m_addr_valid = noise & ~g;
      m_addr       = 3'($urandom);
      tick();
      check_output("addr_wait_cycle", 32'(state), 32'(stay));
    end
    noise        = 3'($urandom);
    m_addr_valid = g | (noise & ~g);
    m_addr       = (noise & ~g) | (b ? g : 3'b000);
    tick();
    m_addr_valid = 3'b000;
  endtask

  // One complete transaction starting from a sampled IDLE state.
  task automatic apply_stimulus(input logic [2:0] req, input logic [1:0] addr, input int rdy_delay,
                                input int gap1, input int gap0, input int route_len,
                                input logic [2:0] exp_grant, input logic [1:0] exp_sel);
    logic [2:0] sel_oh;
    logic [2:0] noise;
    sel_oh       = 3'b001 << exp_sel;
    s_hold       = 3'b000;
    s_ready      = 3'b000;
    m_addr_valid = 3'b000;
    m_addr       = 3'b000;
    m_req        = req;
    tick();
    check_output("txn_grant_state", 32'(state), 32'(ST_GRANT));
    check_output("txn_grant_onehot", 32'(grant), 32'(exp_grant));
    check_output("txn_sel_before_decode", 32'(slave_sel), 32'd3);
    send_bit(gap1, addr[1], exp_grant, ST_GRANT);
    check_output("txn_decode_state", 32'(state), 32'(ST_DECODE));
    check_output("txn_decode_sel", 32'(slave_sel), 32'd3);
    send_bit(gap0, addr[0], exp_grant, ST_DECODE);
    if (exp_sel == 2'd3) begin
      check_output("txn_nosl_state", 32'(state), 32'(ST_RELEASE));
      check_output("txn_nosl_sel", 32'(slave_sel), 32'd3);
      check_output("txn_nosl_route", 32'(route_en), 32'd0);
      check_output("txn_nosl_grant", 32'(grant), 32'd0);
    end else begin
      check_output("txn_wait_state", 32'(state), 32'(ST_WAIT));
      check_output("txn_wait_sel", 32'(slave_sel), 32'(exp_sel));
      check_output("txn_wait_grant", 32'(grant), 32'(exp_grant));
      for (int i = 0; i < rdy_delay; i++) begin
        noise   = 3'($urandom);
        m_req   = exp_grant | noise;
        s_ready = noise & ~sel_oh;
        s_hold  = 3'($urandom) & ~sel_oh;
        tick();
        check_output("txn_wait_hold_state", 32'(state), 32'(ST_WAIT));
      end
      s_ready = sel_oh | 3'($urandom);
      tick();
      check_output("txn_route_state", 32'(state), 32'(ST_ROUTE));
      check_output("txn_route_en", 32'(route_en), 32'd1);
      check_output("txn_route_grant", 32'(grant), 32'(exp_grant));
      check_output("txn_route_sel", 32'(slave_sel), 32'(exp_sel));
      for (int i = 1; i < route_len; i++) begin
        m_req  = exp_grant | 3'($urandom);
        s_hold = 3'($urandom) & ~sel_oh;
        tick();
        check_output("txn_route_stay", 32'(state), 32'(ST_ROUTE));
      end
      m_req = 3'($urandom) & ~exp_grant;
      tick();
      check_output("txn_release_state", 32'(state), 32'(ST_RELEASE));
      check_output("txn_release_grant", 32'(grant), 32'd0);
      check_output("txn_release_route", 32'(route_en), 32'd0);
      check_output("txn_release_sel", 32'(slave_sel), 32'(exp_sel));
    end
    check_output("txn_no_timeout", 32'(timeout_err), 32'd0);
    for (int i = 1; i < IDLE_GAP; i++) begin
      m_req = 3'($urandom);
      tick();
      check_output("txn_gap_state", 32'(state), 32'(ST_RELEASE));
      check_output("txn_gap_grant", 32'(grant), 32'd0);
    end
    tick();
    check_output("txn_idle_state", 32'(state), 32'(ST_IDLE));
    check_output("txn_idle_sel", 32'(slave_sel), 32'd3);
    m_req        = 3'b000;
    s_ready      = 3'b000;
    s_hold       = 3'b000;
    m_addr_valid = 3'b000;
  endtask

  logic [2:0] exp_seq [4];
  int         nonhold;
  int         held;
  int         n;
  logic       hold_now;
  logic [2:0] rreq;
  logic [1:0] raddr;
  int         w;

  initial begin
    reset        = 1'b0;
    m_req        = 3'b000;
    m_addr       = 3'b000;
    m_addr_valid = 3'b000;
    s_ready      = 3'b000;
    s_hold       = 3'b000;

    vecs[0] = '{3'b001, 2'b01, 0, 3'b001, 2'd1};
    vecs[1] = '{3'b111, 2'b10, 2, 3'b010, 2'd2};
    vecs[2] = '{3'b011, 2'b00, 1, 3'b001, 2'd0};
    vecs[3] = '{3'b100, 2'b11, 0, 3'b100, 2'd3};
    vecs[4] = '{3'b110, 2'b01, 3, 3'b010, 2'd1};
    vecs[5] = '{3'b101, 2'b10, 5, 3'b100, 2'd2};

    exp_seq[0] = 3'b001;
    exp_seq[1] = 3'b010;
    exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_state", 32'(state), 32'(ST_IDLE));
    check_output("reset_grant", 32'(grant), 32'd0);
    check_output("reset_sel", 32'(slave_sel), 32'd3);
    check_output("reset_route", 32'(route_en), 32'd0);
    check_output("reset_timeout", 32'(timeout_err), 32'd0);

    m_req = 3'b001;
    reset = 1'b1;
    tick();
    check_output("first_edge_no_grant_state", 32'(state), 32'(ST_IDLE));
    check_output("first_edge_no_grant", 32'(grant), 32'd0);
    m_req      = 3'b000;
    model_last = 2;

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].req, vecs[i].addr, vecs[i].rdy_delay, i % 3, (i + 1) % 3,
                     1 + (i % 3), vecs[i].exp_grant, vecs[i].exp_sel);
      model_last = onehot_index(vecs[i].exp_grant);
    end

    for (int t = 0; t < 30; t++) begin
      rreq  = 3'($urandom_range(1, 7));
      raddr = 2'($urandom_range(0, 3));
      w     = rr_winner(rreq, model_last);
      apply_stimulus(rreq, raddr, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)), int'($urandom_range(1, 4)),
                     3'(3'b001 << w), raddr);
      model_last = w;
    end

    $display("[TB] reset during ROUTE");
    m_req = 3'b100;
    tick();
    check_output("d_grant_state", 32'(state), 32'(ST_GRANT));
    check_output("d_grant", 32'(grant), 32'b100);
    m_addr_valid = 3'b100;
    m_addr       = 3'b000;
    tick();
    m_addr = 3'b100;
    tick();
    check_output("d_wait_sel", 32'(slave_sel), 32'd1);
    m_addr_valid = 3'b000;
    s_ready      = 3'b010;
    tick();
    check_output("d_route_state", 32'(state), 32'(ST_ROUTE));
    #2;
    reset = 1'b0;
    #1;
    check_output("d_async_state", 32'(state), 32'(ST_IDLE));
    check_output("d_async_grant", 32'(grant), 32'd0);
    check_output("d_async_sel", 32'(slave_sel), 32'd3);
    check_output("d_async_route", 32'(route_en), 32'd0);
    check_output("d_async_timeout", 32'(timeout_err), 32'd0);
    m_req   = 3'b111;
    m_addr  = 3'b000;
    s_ready = 3'b111;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check_output("d_post_reset_idle", 32'(state), 32'(ST_IDLE));
    tick();
    check_output("d_post_reset_grant_state", 32'(state), 32'(ST_GRANT));

    $display("[TB] all masters requesting, each transfer ends by timeout");
    for (int k = 0; k < 4; k++) begin
      wait_for_state(ST_GRANT, 20);
      check_output("b_grant_order", 32'(grant), 32'(exp_seq[k]));
      m_addr_valid = 3'b111;
      m_addr       = 3'b000;
      tick();
      check_output("b_decode", 32'(state), 32'(ST_DECODE));
      m_addr = 3'b111;
      tick();
      check_output("b_wait", 32'(state), 32'(ST_WAIT));
      m_addr_valid = 3'b000;
      tick();
      check_output("b_route", 32'(state), 32'(ST_ROUTE));
      check_output("b_route_sel", 32'(slave_sel), 32'd1);
      check_output("b_route_en", 32'(route_en), 32'd1);
      n = 0;
      while (timeout_err !== 1'b1 && n < 300) begin
        tick();
        n++;
      end
      check_output("b_timeout_pulse", 32'(timeout_err), 32'd1);
      check_output("b_timeout_release", 32'(state), 32'(ST_RELEASE));
    end

    $display("[TB] slave hold freezes the watchdog");
    reset        = 1'b0;
    m_req        = 3'b000;
    s_ready      = 3'b000;
    s_hold       = 3'b000;
    m_addr_valid = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_req = 3'b001;
    tick();
    tick();
    check_output("c_grant", 32'(grant), 32'b001);
    m_addr_valid = 3'b001;
    m_addr       = 3'b000;
    tick();
    tick();
    check_output("c_wait", 32'(state), 32'(ST_WAIT));
    check_output("c_wait_sel", 32'(slave_sel), 32'd0);
    m_addr_valid = 3'b000;
    s_ready      = 3'b111;
    nonhold      = 0;
    held         = 0;
    n            = 0;
    while (timeout_err !== 1'b1 && n < 1000) begin
      hold_now = (state == ST_ROUTE) && (held < 300);
      s_hold   = hold_now ? 3'b001 : 3'b000;
      if ((state == ST_WAIT || state == ST_ROUTE) && !hold_now) nonhold++;
      if (hold_now) held++;
      tick();
      n++;
    end
    check_output("c_timeout_seen", 32'(timeout_err), 32'd1);
    check_output("c_hold_cycles_survived", 32'(held), 32'd300);
    check_output("c_nonhold_cycles", 32'(nonhold), 32'd200);
    check_output("c_release_state", 32'(state), 32'(ST_RELEASE));
    check_output("c_release_grant", 32'(grant), 32'd0);
    s_hold = 3'b000;
    m_req  = 3'b000;
    tick();
    check_output("c_pulse_one_cycle", 32'(timeout_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
